// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped UART transmitter with TX FIFO and status register
// Optional even-parity bit after the data bits when UART_TX_PARITY_EN is defined.
module mmio_uart_tx #(
  parameter int          CLK_FREQ   = 100_000_000,
  parameter int          BAUD       = 115_200,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_2000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        we_i,
  output logic [31:0] rdata_o,
  output logic        hit_o,
  output logic        tx_o
);

  localparam int          CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int          BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int          PTR_W        = $clog2(FIFO_DEPTH);
  localparam int          CNT_W        = PTR_W + 1;
  localparam logic [31:0] STATUS_ADDR  = BASE_ADDR + 32'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t            state, state_n;
  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift, shift_n;
  logic              tx_n;
  logic              data_sel, stat_sel, fifo_empty, fifo_full, baud_last;
  logic              pop, push_req, push, ovf_set, ovf_clr;
  logic              unused_wdata;

  assign data_sel   = (addr_i == BASE_ADDR);
  assign stat_sel   = (addr_i == STATUS_ADDR);
  assign hit_o      = data_sel | stat_sel;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign baud_last  = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
  // A pop happens either from idle or on the last stop-bit cycle, giving gapless frames.
  assign pop        = !fifo_empty && ((state == S_IDLE) || ((state == S_STOP) && baud_last));
  assign push_req   = we_i && data_sel;
  assign push       = push_req && (!fifo_full || pop);
  assign ovf_set    = push_req && fifo_full && !pop;
  assign ovf_clr    = we_i && stat_sel && wdata_i[3];
  assign unused_wdata = ^wdata_i[31:8];

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (pop) state_n = S_START;
      S_START: if (baud_last) state_n = S_DATA;
`ifdef UART_TX_PARITY_EN
      S_DATA:   if (baud_last && bit_cnt == 3'd7) state_n = S_PARITY;
      S_PARITY: if (baud_last) state_n = S_STOP;
`else
      S_DATA:   if (baud_last && bit_cnt == 3'd7) state_n = S_STOP;
`endif
      S_STOP:  if (baud_last) state_n = pop ? S_START : S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

`ifdef UART_TX_PARITY_EN
  logic parity;
  always_ff @(posedge clk_i) begin
    if (rst_i)    parity <= 1'b0;
    else if (pop) parity <= ^mem[rd_ptr];
  end
`endif

  always_comb begin
    shift_n = shift;
    if (pop)                             shift_n = mem[rd_ptr];
    else if (state == S_DATA && baud_last) shift_n = {1'b0, shift[7:1]};
    tx_n = 1'b1;
    case (state_n)
      S_START:  tx_n = 1'b0;
      S_DATA:   tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_n = parity;
`endif
      default:  tx_n = 1'b1;
    endcase
    rdata_o = 32'h0;
    if (stat_sel)
      rdata_o = {16'h0, 8'(count), 4'h0, overflow, fifo_empty, fifo_full, state != S_IDLE};
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= wdata_i[7:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_o     <= 1'b1;
      shift    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      tx_o  <= tx_n;
      shift <= shift_n;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
      if (state == S_IDLE || baud_last) baud_cnt <= '0;
      else                              baud_cnt <= baud_cnt + BAUD_W'(1);
      if (state != S_DATA)    bit_cnt <= '0;
      else if (baud_last)     bit_cnt <= bit_cnt + 3'd1;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - scoreboard bench for mmio_uart_tx (16 clk/bit, 4-entry FIFO)
module tb_mmio_uart_tx;
  localparam int          N     = 16;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_2000;
  localparam logic [31:0] STAT  = 32'h0000_2004;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * N;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata, rdata;
  logic        we, hit, tx;

  mmio_uart_tx #(.CLK_FREQ(16), .BAUD(1), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .wdata_i(wdata), .we_i(we),
    .rdata_o(rdata), .hit_o(hit), .tx_o(tx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  b;
    logic [31:0] start_e;
  } frame_t;

  frame_t     exp_q[$];
  logic [7:0] mq[$];
  int         cyc = 0;
  int         next_free = 0;
  bit         ovf_m = 0;
  bit         last_rst = 0;
  int         frames_exp = 0, frames_seen = 0;
  int         checks = 0, errors = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: byte queue plus a line-occupancy timeline; one frame per FRAME cycles.
  initial forever begin
    bit pop, full, preq, clr;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      exp_q.delete();
      next_free = 0;
      ovf_m     = 0;
      last_rst  = 1;
    end else begin
      frame_t f;
      last_rst = 0;
      full = (mq.size() == DEPTH);
      pop  = (mq.size() > 0) && (cyc >= next_free);
      if (pop) begin
        f.b = mq.pop_front();
        f.start_e = 32'(cyc);
        exp_q.push_back(f);
        next_free = cyc + FRAME;
        frames_exp++;
      end
      preq = we && (addr == BASE);
      clr  = we && (addr == STAT) && wdata[3];
      if (preq && (!full || pop)) mq.push_back(wdata[7:0]);
      if (preq && full && !pop) ovf_m = 1;
      else if (clr)             ovf_m = 0;
    end
    cyc++;
  end

  function automatic logic [31:0] status_m();
    int sz = mq.size();
    return {16'h0, 8'(sz), 4'h0, ovf_m, sz == 0, sz == DEPTH, (cyc - 1) < next_free};
  endfunction

  function automatic logic exp_bit(logic [7:0] b, int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Monitor: detects a start bit, pops the expected frame and checks start time and every sample.
  initial begin
    bit     in_frame = 0, have = 0;
    int     pos = 0, bad = 0;
    frame_t cur;
    cur = '0;
    forever begin
      @(negedge clk);
      if (last_rst) begin
        in_frame = 0;
      end else begin
        if (!in_frame && tx === 1'b0) begin
          in_frame = 1; pos = 0; bad = 0;
          frames_seen++;
          checks++;
          if (exp_q.size() == 0) begin
            have = 0;
            errors++;
            $display("FAIL unexpected_frame: start at cycle %0d with no byte expected", cyc - 1);
          end else begin
            have = 1;
            cur = exp_q.pop_front();
            if (cur.start_e != 32'(cyc - 1)) begin
              errors++;
              $display("FAIL frame_start: byte %h started at %0d expected %0d", cur.b, cyc - 1, cur.start_e);
            end
          end
        end
        if (in_frame) begin
          if (have && tx !== exp_bit(cur.b, pos / N)) bad++;
          pos++;
          if (pos == FRAME) begin
            in_frame = 0;
            if (have) begin
              checks++;
              if (bad != 0) begin
                errors++;
                $display("FAIL frame_bits: byte %h had %0d wrong samples expected 0", cur.b, bad);
              end
            end
          end
        end
      end
    end
  end

  task automatic drive(bit w, logic [31:0] a, logic [31:0] d);
    we = w; addr = a; wdata = d;
    @(posedge clk); #1;
    we = 1'b0; addr = 32'h0; wdata = 32'h0;
  endtask

  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_status(string nm);
    addr = STAT; #1;
    chk(nm, rdata, status_m());
    addr = 32'h0;
  endtask

  task automatic read_stat(output logic [31:0] v);
    addr = STAT; #1;
    v = rdata;
    addr = 32'h0;
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] addrs [5];
    logic [7:0]  hola [4];
    int          k, bad;
    bit          found;
    we = 0; addr = 0; wdata = 0; rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    chk("reset_tx", 32'(tx), 32'h1);
    read_stat(v);
    chk("reset_status", v, 32'h0000_0004);
    addrs[0] = BASE; addrs[1] = STAT; addrs[2] = BASE + 8; addrs[3] = BASE - 4; addrs[4] = 32'h1000_2000;
    foreach (addrs[i]) begin
      addr = addrs[i]; #1;
      chk("hit", 32'(hit), 32'((addrs[i] == BASE) || (addrs[i] == STAT)));
      if (addrs[i] != STAT) chk("rdata_nonstatus", rdata, 32'h0);
    end
    addr = 0;

    // Single frame: 'H', tx low from the edge after the store.
    drive(1, BASE, 32'h48);
    chk("latency_pre", 32'(tx), 32'h1);
    idle(1);
    chk("latency_start", 32'(tx), 32'h0);
    idle(80);
    read_stat(v);
    chk("busy_mid_frame", 32'(v[0]), 32'h1);
    idle(FRAME);
    read_stat(v);
    chk("idle_after_frame", v, 32'h0000_0004);

    // Back-to-back "hola".
    hola[0] = 8'h68; hola[1] = 8'h6F; hola[2] = 8'h6C; hola[3] = 8'h61;
    foreach (hola[i]) begin
      drive(1, BASE, {24'h0, hola[i]});
      check_status("hola_status");
    end
    read_stat(v);
    chk("hola_count_peak", 32'(v[15:8]), 32'd3);
    idle(4 * FRAME + 4);
    read_stat(v);
    chk("hola_empty", 32'(v[2]), 32'h1);

    drive(1, BASE, 32'h07);
    drive(1, BASE, 32'h03);
    idle(2 * FRAME + 4);

    // Overflow: sixth rapid store is dropped.
    for (int i = 0; i < 6; i++) drive(1, BASE, 32'hC0 + 32'(i));
    check_status("ovf_status");
    read_stat(v);
    chk("ovf_set", 32'(v[3]), 32'h1);
    chk("ovf_count", 32'(v[15:8]), 32'd4);
    drive(1, STAT, 32'h8);
    read_stat(v);
    chk("ovf_clear", 32'(v[3]), 32'h0);

    // Full FIFO with a store landing on the pop edge.
    found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      if (cyc == next_free && mq.size() == DEPTH) found = 1;
      else idle(1);
    end
    chk("fullpop_reached", 32'(found), 32'h1);
    drive(1, BASE, 32'hA5);
    read_stat(v);
    chk("fullpop_count", 32'(v[15:8]), 32'd4);
    chk("fullpop_no_ovf", 32'(v[3]), 32'h0);
    idle(5 * FRAME + 8);
    check_status("drain_status");

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      int r = $urandom_range(0, 9);
      if (r < 3)       drive(1, BASE, $urandom);
      else if (r == 3) drive(1, STAT, $urandom);
      else if (r == 4) drive(1, BASE + 32'($urandom_range(1, 3)), $urandom);
      else if (r == 5) drive(1, $urandom, $urandom);
      else             drive(0, BASE, $urandom);
      if (i % 8 == 0) check_status("rand_status");
    end
    idle(6 * FRAME);
    check_status("rand_drain_status");

    // Reset during data bit 3 aborts the frame for good.
    drive(1, BASE, 32'h5A);
    k = cyc;
    while (cyc < k + 4 * N + 4) idle(1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("rst_mid_tx", 32'(tx), 32'h1);
    read_stat(v);
    chk("rst_mid_status", v, 32'h0000_0004);
    bad = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      idle(1);
      if (tx !== 1'b1) bad++;
    end
    chk("rst_no_resend", 32'(bad), 32'h0);

    chk("exp_drained", 32'(exp_q.size()), 32'h0);
    chk("frame_count", 32'(frames_seen), 32'(frames_exp));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
